// File: rtl/cardinal_nic_fifo_pkg.sv
// Shared definitions for the NIC channel buffer: default geometry, status encodings, clog2 helper.
package cardinal_nic_fifo_pkg;

   localparam int NIC_DEF_BUFFER_WIDTH = 64;
   localparam int NIC_DEF_DEPTH        = 4;
   localparam int NIC_DEF_AF_THRESH    = 3;

   typedef enum logic [1:0] {
      NIC_ST_OK        = 2'b00,
      NIC_ST_OVERFLOW  = 2'b01,
      NIC_ST_UNDERFLOW = 2'b10,
      NIC_ST_BOTH      = 2'b11
   } nic_status_e;

   function automatic int nic_clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic nic_status_e nic_status(input logic ovf, input logic unf);
      return nic_status_e'({unf, ovf});
   endfunction

endpackage

// File: rtl/cardinal_nic_fifo_if.sv
// Channel-side handshake bundle of the NIC buffer; master is the producer/consumer, slave is the FIFO.
interface cardinal_nic_fifo_if
   import cardinal_nic_fifo_pkg::*;
#(
   parameter int BUFFER_WIDTH = NIC_DEF_BUFFER_WIDTH,
   parameter int DEPTH        = NIC_DEF_DEPTH
) ();
   localparam int CNT_W = nic_clog2(DEPTH) + 1;

   logic                    write_en;
   logic                    read_en;
   logic                    clear_err;
   logic [BUFFER_WIDTH-1:0] data_in;
   logic [BUFFER_WIDTH-1:0] data_out;
   logic                    full;
   logic                    empty;
   logic                    almost_full;
   logic [CNT_W-1:0]        count;
   logic                    overflow;
   logic                    underflow;

   modport master (
      output write_en, read_en, clear_err, data_in,
      input  data_out, full, empty, almost_full, count, overflow, underflow
   );

   modport slave (
      input  write_en, read_en, clear_err, data_in,
      output data_out, full, empty, almost_full, count, overflow, underflow
   );
endinterface

// File: rtl/cardinal_nic_ptr.sv
// Mod-DEPTH pointer with increment enable; wraps naturally since DEPTH is a power of two.
module cardinal_nic_ptr
   import cardinal_nic_fifo_pkg::*;
#(
   parameter  int DEPTH = NIC_DEF_DEPTH,
   localparam int PTR_W = nic_clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_i,
   output logic [PTR_W-1:0] ptr_o
);
   logic [PTR_W-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (inc_i) ptr_d = ptr_q + PTR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

   assign ptr_o = ptr_q;
endmodule

// File: rtl/cardinal_nic_fifo.sv
// Multi-entry FWFT NIC channel buffer with occupancy, almost-full and sticky error flags.
// All outputs come straight from registers; the head word lives in its own register.
module cardinal_nic_fifo
   import cardinal_nic_fifo_pkg::*;
#(
   parameter int BUFFER_WIDTH = NIC_DEF_BUFFER_WIDTH,
   parameter int DEPTH        = NIC_DEF_DEPTH,
   parameter int AF_THRESH    = NIC_DEF_AF_THRESH
) (
   input logic                clk,
   input logic                reset,
   cardinal_nic_fifo_if.slave bus
);
   localparam int PTR_W = nic_clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [BUFFER_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]        rd_ptr, wr_ptr, rd_nxt;
   logic                    rd_ok, wr_ok;

   logic [CNT_W-1:0]        count_q, count_d;
   logic                    full_q, full_d, empty_q, empty_d, af_q, af_d;
   logic                    ovf_q, ovf_d, unf_q, unf_d;
   logic [BUFFER_WIDTH-1:0] head_q, head_d;

   assign rd_ok  = bus.read_en & ~empty_q;
   assign wr_ok  = bus.write_en & (~full_q | bus.read_en);
   assign rd_nxt = rd_ptr + PTR_W'(1);

   cardinal_nic_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk(clk), .reset(reset), .inc_i(rd_ok), .ptr_o(rd_ptr)
   );

   cardinal_nic_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk(clk), .reset(reset), .inc_i(wr_ok), .ptr_o(wr_ptr)
   );

   always_comb begin
      count_d = count_q;
      if (wr_ok && !rd_ok)      count_d = count_q + CNT_W'(1);
      else if (rd_ok && !wr_ok) count_d = count_q - CNT_W'(1);
      full_d  = (count_d == CNT_W'(DEPTH));
      empty_d = (count_d == '0);
      af_d    = (count_d >= CNT_W'(AF_THRESH));

      // With more than one entry, the next head is already in memory; otherwise
      // an incoming word either fills an empty FIFO or replaces the last entry.
      head_d = head_q;
      if (rd_ok && count_q > CNT_W'(1))  head_d = mem_q[rd_nxt];
      else if (wr_ok && (empty_q || rd_ok)) head_d = bus.data_in;
      else if (rd_ok)                       head_d = '0;

      // A new error event outranks a simultaneous clear.
      ovf_d = (bus.write_en & full_q & ~bus.read_en) | (ovf_q & ~bus.clear_err);
      unf_d = (bus.read_en & empty_q) | (unf_q & ~bus.clear_err);
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr] <= bus.data_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         af_q    <= 1'b0;
         head_q  <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         af_q    <= af_d;
         head_q  <= head_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign bus.data_out    = head_q;
   assign bus.count       = count_q;
   assign bus.full        = full_q;
   assign bus.empty       = empty_q;
   assign bus.almost_full = af_q;
   assign bus.overflow    = ovf_q;
   assign bus.underflow   = unf_q;
endmodule

// File: tb/tb_cardinal_nic_fifo.sv
// Directed bench for the NIC channel buffer: vector table plus wrap-around and reset sequences.
module tb_cardinal_nic_fifo;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cardinal_nic_fifo_if #(.BUFFER_WIDTH(64), .DEPTH(4)) bus ();

   cardinal_nic_fifo #(.BUFFER_WIDTH(64), .DEPTH(4), .AF_THRESH(3)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   typedef struct {
      string       name;
      logic        we, re, clr;
      logic [63:0] din;
      logic [63:0] dout;
      logic [2:0]  cnt;
      logic        full, empty, af, ovf, unf;
   } vec_t;

   vec_t vq[$];
   int   n_chk = 0;
   int   n_err = 0;

   function automatic void add(input string nm, input logic we, re, clr, input logic [63:0] din,
                               input logic [63:0] dout, input logic [2:0] cnt,
                               input logic full, empty, af, ovf, unf);
      vec_t v;
      v.name = nm; v.we = we; v.re = re; v.clr = clr; v.din = din; v.dout = dout;
      v.cnt = cnt; v.full = full; v.empty = empty; v.af = af; v.ovf = ovf; v.unf = unf;
      vq.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic we, re, clr, input logic [63:0] din);
      bus.write_en  = we;
      bus.read_en   = re;
      bus.clear_err = clr;
      bus.data_in   = din;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string nm, input logic [63:0] dout, input logic [2:0] cnt,
                          input logic full, empty, af, ovf, unf);
      chk({nm, ".data_out"}, bus.data_out, dout);
      chk({nm, ".count"}, 64'(bus.count), 64'(cnt));
      chk({nm, ".full"}, 64'(bus.full), 64'(full));
      chk({nm, ".empty"}, 64'(bus.empty), 64'(empty));
      chk({nm, ".almost_full"}, 64'(bus.almost_full), 64'(af));
      chk({nm, ".overflow"}, 64'(bus.overflow), 64'(ovf));
      chk({nm, ".underflow"}, 64'(bus.underflow), 64'(unf));
   endtask

   localparam logic [63:0] A1 = 64'hA1A1_0000_0000_0001, A2 = 64'hA2A2_0000_0000_0002;
   localparam logic [63:0] A3 = 64'hA3A3_0000_0000_0003, A4 = 64'hA4A4_0000_0000_0004;
   localparam logic [63:0] A5 = 64'hA5A5_0000_0000_0005, B1 = 64'hB1B1_0000_0000_00B1;
   localparam logic [63:0] C1 = 64'hC1C1_0000_0000_00C1, D1 = 64'hD1D1_0000_0000_00D1;
   localparam logic [63:0] D2 = 64'hD2D2_0000_0000_00D2;

   initial begin
      logic [63:0] model[$];
      logic [63:0] exp_head;
      int          j;

      //   name         we    re    clr   din  dout cnt full empty af ovf unf
      add("idle0",      0,    0,    0,    0,   0,   0,  0,   1,   0, 0,  0);
      add("idle1",      0,    0,    0,    0,   0,   0,  0,   1,   0, 0,  0);
      add("idle2",      0,    0,    0,    0,   0,   0,  0,   1,   0, 0,  0);
      add("wrA1",       1,    0,    0,    A1,  A1,  1,  0,   0,   0, 0,  0);
      add("wrA2",       1,    0,    0,    A2,  A1,  2,  0,   0,   0, 0,  0);
      add("wrA3",       1,    0,    0,    A3,  A1,  3,  0,   0,   1, 0,  0);
      add("wrA4",       1,    0,    0,    A4,  A1,  4,  1,   0,   1, 0,  0);
      add("wrA5_drop",  1,    0,    0,    A5,  A1,  4,  1,   0,   1, 1,  0);
      add("wrrdB1_full",1,    1,    0,    B1,  A2,  4,  1,   0,   1, 1,  0);
      add("rd_A2",      0,    1,    0,    0,   A3,  3,  0,   0,   1, 1,  0);
      add("rd_A3",      0,    1,    0,    0,   A4,  2,  0,   0,   0, 1,  0);
      add("rd_A4",      0,    1,    0,    0,   B1,  1,  0,   0,   0, 1,  0);
      add("rd_B1",      0,    1,    0,    0,   0,   0,  0,   1,   0, 1,  0);
      add("clr_ovf",    0,    0,    1,    0,   0,   0,  0,   1,   0, 0,  0);
      add("wrrdC1_empty",1,   1,    0,    C1,  C1,  1,  0,   0,   0, 0,  1);
      add("clr_unf",    0,    0,    1,    0,   C1,  1,  0,   0,   0, 0,  0);
      add("rd_C1",      0,    1,    0,    0,   0,   0,  0,   1,   0, 0,  0);
      add("rd_clr_same",0,    1,    1,    0,   0,   0,  0,   1,   0, 0,  1);
      add("clr_unf2",   0,    0,    1,    0,   0,   0,  0,   1,   0, 0,  0);
      add("wrD1",       1,    0,    0,    D1,  D1,  1,  0,   0,   0, 0,  0);
      add("wrrdD2_one", 1,    1,    0,    D2,  D2,  1,  0,   0,   0, 0,  0);
      add("rd_D2",      0,    1,    0,    0,   0,   0,  0,   1,   0, 0,  0);

      reset = 1'b1;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk_all("reset", 0, 0, 0, 1, 0, 0, 0);
      reset = 1'b0;

      foreach (vq[i]) begin
         step(vq[i].we, vq[i].re, vq[i].clr, vq[i].din);
         chk_all(vq[i].name, vq[i].dout, vq[i].cnt, vq[i].full, vq[i].empty,
                 vq[i].af, vq[i].ovf, vq[i].unf);
      end

      // Wrap-around: 10 rounds of 3 writes then 3 reads against a queue model.
      j = 1;
      for (int r = 0; r < 10; r++) begin
         for (int k = 0; k < 6; k++) begin
            if (k < 3) begin
               logic [63:0] w;
               w = 64'(j) * 64'h0101;
               j++;
               step(1, 0, 0, w);
               model.push_back(w);
            end else begin
               step(0, 1, 0, 0);
               void'(model.pop_front());
            end
            exp_head = (model.size() != 0) ? model[0] : 64'h0;
            chk($sformatf("wrap%0d_%0d.data_out", r, k), bus.data_out, exp_head);
            chk($sformatf("wrap%0d_%0d.count", r, k), 64'(bus.count), 64'(model.size()));
         end
      end

      // Reset mid-operation with a write pending.
      step(1, 0, 0, 64'hE1);
      step(1, 0, 0, 64'hE2);
      step(1, 0, 0, 64'hE3);
      chk("pre_reset.count", 64'(bus.count), 64'd3);
      reset = 1'b1;
      step(1, 0, 0, 64'hEE);
      chk_all("mid_reset", 0, 0, 0, 1, 0, 0, 0);
      reset = 1'b0;
      step(0, 0, 0, 0);
      chk_all("post_reset", 0, 0, 0, 1, 0, 0, 0);
      step(0, 1, 0, 0);
      chk_all("post_reset_rd", 0, 0, 0, 1, 0, 0, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
